// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO 7-segment display: the active-low hex font,
// the blank segment pattern and the default scan prescale.
package gpio_pkg;

  typedef logic [6:0] seg_t;

  localparam int   CLK_DIV_DEFAULT = 100000;
  localparam seg_t SEG_OFF         = 7'h7F;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg_t seg_decode(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg
  import gpio_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/gpio_display.sv
// Latches the GPIO output word on its write strobe and scans it as hex digits
// across a multiplexed 7-segment display with registered anode/segment drives.
module gpio_display
  import gpio_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int N_DIGITS    = 8,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_ZEROS = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         gpio_out,
  input  logic                gpio_we,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [31:0]         dato_mostrado
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_IDLE    = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                  : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_IDLE   = (ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic                DP_IDLE    = (ACTIVE_LOW != 0);

  logic [31:0]         dato_q,  dato_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q,   idx_d;
  logic [N_DIGITS-1:0] an_q,    an_d;
  logic [6:0]          seg_q,   seg_d;
  logic                dp_q;

  logic                tick;
  logic [3:0]          nibble_sel;
  logic [6:0]          seg_dec;
  logic [6:0]          seg_sel;
  logic [IW-1:0]       top_nz;
  logic                blank;
  logic [N_DIGITS-1:0] onehot;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign dato_d  = gpio_we ? gpio_out : dato_q;

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  assign nibble_sel = 4'(dato_q >> {idx_q, 2'b00});

  hex7seg u_hex7seg (
    .nibble_i (nibble_sel),
    .seg_o    (seg_dec)
  );

  // Position of the most significant nonzero nibble; 0 when the value is 0,
  // which keeps digit 0 lit.
  always_comb begin
    top_nz = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (dato_q[4*i +: 4] != 4'h0) begin
        top_nz = IW'(i);
      end
    end
  end

  assign blank   = (BLANK_ZEROS != 0) && (idx_q > top_nz);
  assign seg_sel = blank ? SEG_OFF : seg_dec;
  assign onehot  = N_DIGITS'(1) << idx_q;
  assign an_d    = (ACTIVE_LOW != 0) ? ~onehot : onehot;
  assign seg_d   = (ACTIVE_LOW != 0) ? seg_sel : ~seg_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dato_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= AN_IDLE;
      seg_q   <= SEG_IDLE;
      dp_q    <= DP_IDLE;
    end else begin
      dato_q  <= dato_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= DP_IDLE;
    end
  end

  assign an            = an_q;
  assign seg           = seg_q;
  assign dp            = dp_q;
  assign dato_mostrado = dato_q;

endmodule

// File: tb/tb_gpio_display.sv
// Scoreboard bench for gpio_display: four parameterisations share one stimulus
// stream and are compared every cycle against a slot-arithmetic display model.
module tb_gpio_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] gpio_out = '0;
  logic        gpio_we = 1'b0;

  logic [7:0]  an_a, an_b, an_c;
  logic [2:0]  an_d;
  logic [6:0]  seg_a, seg_b, seg_c, seg_d;
  logic        dp_a, dp_b, dp_c, dp_d;
  logic [31:0] dato_a, dato_b, dato_c, dato_d;

  always #5 clk = ~clk;

  gpio_display #(.CLK_DIV(4), .N_DIGITS(8), .ACTIVE_LOW(1), .BLANK_ZEROS(0)) u_a (
    .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_we(gpio_we),
    .an(an_a), .seg(seg_a), .dp(dp_a), .dato_mostrado(dato_a));

  gpio_display #(.CLK_DIV(4), .N_DIGITS(8), .ACTIVE_LOW(1), .BLANK_ZEROS(1)) u_b (
    .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_we(gpio_we),
    .an(an_b), .seg(seg_b), .dp(dp_b), .dato_mostrado(dato_b));

  gpio_display #(.CLK_DIV(4), .N_DIGITS(8), .ACTIVE_LOW(0), .BLANK_ZEROS(0)) u_c (
    .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_we(gpio_we),
    .an(an_c), .seg(seg_c), .dp(dp_c), .dato_mostrado(dato_c));

  gpio_display #(.CLK_DIV(1), .N_DIGITS(3), .ACTIVE_LOW(1), .BLANK_ZEROS(0)) u_d (
    .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_we(gpio_we),
    .an(an_d), .seg(seg_d), .dp(dp_d), .dato_mostrado(dato_d));

  typedef struct packed {
    logic [7:0]  an_a;
    logic [6:0]  seg_a;
    logic [7:0]  an_b;
    logic [6:0]  seg_b;
    logic [7:0]  an_c;
    logic [6:0]  seg_c;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic [31:0] dato;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          n = 0;
  logic [31:0] model_val = '0;

  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // Output shown after the n-th clock edge since reset release, for value v.
  function automatic logic [14:0] model(input int nn, input logic [31:0] v, input int cdiv,
                                        input int nd, input bit al, input bit bz);
    int         d;
    int         hi;
    logic [3:0] nib;
    logic [6:0] s;
    logic [7:0] a;
    logic [7:0] mask;
    d    = ((nn - 1) / cdiv) % nd;
    nib  = v[4*d +: 4];
    s    = font[nib];
    hi   = 0;
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] != 4'h0) hi = i;
    if (bz && d > hi) s = 7'h7F;
    mask = 8'((1 << nd) - 1);
    a    = ~(8'(1) << d) & mask;
    if (!al) begin
      a = ~a & mask;
      s = ~s;
    end
    return {a, s};
  endfunction

  task automatic cycle(input bit we, input logic [31:0] d);
    exp_t e;
    exp_t g;
    int   nn;
    nn = n + 1;
    {e.an_a, e.seg_a} = model(nn, model_val, 4, 8, 1'b1, 1'b0);
    {e.an_b, e.seg_b} = model(nn, model_val, 4, 8, 1'b1, 1'b1);
    {e.an_c, e.seg_c} = model(nn, model_val, 4, 8, 1'b0, 1'b0);
    {e.an_d, e.seg_d} = model(nn, model_val, 1, 3, 1'b1, 1'b0);
    if (we) model_val = d;
    e.dato = model_val;
    sb.push_back(e);
    gpio_we  = we;
    gpio_out = d;
    @(posedge clk);
    #1;
    n = nn;
    g = sb.pop_front();
    chk("an_a",  {24'b0, an_a},  {24'b0, g.an_a});
    chk("seg_a", {25'b0, seg_a}, {25'b0, g.seg_a});
    chk("an_b",  {24'b0, an_b},  {24'b0, g.an_b});
    chk("seg_b", {25'b0, seg_b}, {25'b0, g.seg_b});
    chk("an_c",  {24'b0, an_c},  {24'b0, g.an_c});
    chk("seg_c", {25'b0, seg_c}, {25'b0, g.seg_c});
    chk("an_d",  {29'b0, an_d},  {24'b0, g.an_d});
    chk("seg_d", {25'b0, seg_d}, {25'b0, g.seg_d});
    chk("dato_a", dato_a, g.dato);
    chk("dato_d", dato_d, g.dato);
    chk("dp_a", {31'b0, dp_a}, 32'd1);
    chk("dp_c", {31'b0, dp_c}, 32'd0);
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 32'h0);
  endtask

  // Reset is raised between clock edges; outputs must go idle without a clock.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset    = 1'b1;
    gpio_we  = 1'b0;
    gpio_out = '0;
    #1;
    chk("rst_an_a",  {24'b0, an_a},  32'h0000_00FF);
    chk("rst_seg_a", {25'b0, seg_a}, 32'h0000_007F);
    chk("rst_dp_a",  {31'b0, dp_a},  32'd1);
    chk("rst_an_c",  {24'b0, an_c},  32'd0);
    chk("rst_seg_c", {25'b0, seg_c}, 32'd0);
    chk("rst_dp_c",  {31'b0, dp_c},  32'd0);
    chk("rst_an_d",  {29'b0, an_d},  32'h0000_0007);
    chk("rst_dato",  dato_a,         32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    n         = 0;
    model_val = '0;
    sb.delete();
  endtask

  initial begin
    do_reset();
    idle(40);

    do_reset();
    idle(5);
    cycle(1'b1, 32'h1234_ABCD);
    idle(40);
    chk("dato_hold", dato_a, 32'h1234_ABCD);

    cycle(1'b1, 32'h0000_00A5);
    idle(34);
    cycle(1'b1, 32'h0000_0000);
    idle(34);

    cycle(1'b1, 32'h0000_0008);
    idle(10);

    while (((n + 1) % 4) != 0) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'hFFFF_FFFF);
    idle(36);

    cycle(1'b1, 32'h0000_0011);
    cycle(1'b1, 32'h0000_0022);
    cycle(1'b1, 32'h3300_0033);
    idle(12);
    chk("last_wins", dato_b, 32'h3300_0033);

    idle(9);
    do_reset();
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
